obstacle_scheduler: RTL and testbench
=====================================

Name: obstacle_scheduler

Overview:
- Game-level sequencer for the obstacle modules (pillars and similar). Each obstacle module is tagged with a 4-bit SELECT_CODE.
- This block chooses the next obstacle with an LFSR, launches it through the selected/done_control handshake, and waits for that obstacle's done pulse.
- It inserts an idle gap between obstacles, counts completed rounds and tracks player lives from collision pulses. It ends the game with a win or a loss.
- It sits between the menu/game-state logic and the bank of obstacle modules.

Parameters:
- N_OBSTACLES, 4, number of obstacle modules; legal range 2..16; codes used are 0..N_OBSTACLES-1.
- ROUNDS_TO_WIN, 8, completed obstacles needed for victory; legal range 1..255.
- LIVES, 3, initial lives; legal range 1..15.
- GAP_CYCLES, 65000000, idle pclk cycles between obstacles (1 s at 65 MHz).
- LAUNCH_TIMEOUT, 16, cycles to wait for working before re-launching.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- pclk  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- play_selected  in  1  level; high while the player is in the game.
- menu_on  in  1  level; high forces an abort to IDLE.
- obstacle_done  in  N_OBSTACLES  one-cycle done pulses; bit i comes from obstacle code i.
- obstacle_working  in  N_OBSTACLES  working flags from the obstacles.
- collision  in  1  one-cycle pulse per player hit.
- selected  out  4  code of the current or next obstacle.
- done_control  out  1  one-cycle launch strobe to the obstacles.
- round_count  out  8  obstacles completed in this game.
- lives  out  4  remaining lives.
- game_over  out  1  level; high in the LOSE state.
- victory  out  1  level; high in the WIN state.
- busy  out  1  high in every state except IDLE, WIN and LOSE.

Behaviour:
Clock and reset:
- Single clock domain, pclk. Reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values: selected=0, done_control=0, round_count=0, lives=LIVES, game_over=0, victory=0, busy=0, state=IDLE, lfsr=LFSR_SEED.

LFSR:
- 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances every cycle in every state.
- pick = lfsr[3:0] mod N_OBSTACLES.
- If pick equals the previous selected and round_count>0, use (pick+1) mod N_OBSTACLES. There are never two identical obstacles in a row.

States and transitions:
- IDLE: round_count=0 and lives=LIVES are reloaded every cycle. On play_selected && !menu_on, go to PICK.
- PICK (1 cycle): register selected=pick, then go to LAUNCH.
- LAUNCH:
  - On the first cycle, done_control=1 for exactly one cycle. selected is already stable, so it is held one cycle before the strobe and throughout.
  - Then wait for obstacle_working[selected]. When it is seen, go to RUN.
  - If it is not seen within LAUNCH_TIMEOUT cycles after the strobe, re-pulse done_control and restart the timeout. Retries are unlimited.
- RUN:
  - When obstacle_done[selected] is seen: round_count+1.
  - If the new count == ROUNDS_TO_WIN, go to WIN; otherwise go to GAP.
  - obstacle_done bits other than selected are ignored.
- GAP: count GAP_CYCLES down to 0, then go to PICK.
- WIN: victory=1. Hold until !play_selected, then go to IDLE.
- LOSE: game_over=1. Hold until !play_selected, then go to IDLE.

Lives:
- In LAUNCH, RUN and GAP, a collision pulse decrements lives.
- When lives reaches 0, go to LOSE on the next cycle. This takes priority over a done pulse in the same cycle.
- Collisions are ignored in IDLE, PICK, WIN and LOSE. lives never underflows.

Abort:
- menu_on or !play_selected in any state other than IDLE, WIN or LOSE goes to IDLE on the next cycle. done_control stays 0.
- The obstacles abort themselves on the same signals.

Simultaneous events:
- Priority in the same cycle: abort > lives-to-zero > done > timeout.
- round_count saturates at 255.

Decomposition:
- Shared package:
  - state encoding (IDLE, PICK, LAUNCH, RUN, GAP, WIN, LOSE, 3 bits);
  - the obstacle SELECT_CODE constants, so that the top level and the obstacles share the same codes;
  - the 65 MHz cycles-per-second constant.
- One natural sub-module: lfsr16. It has pclk, rst, seed, the output value and an advance-enable tied high.

Test Plan:
- Normal launch: rst, then play_selected=1 → PICK after 1 cycle. LAUNCH strobes done_control=1 for 1 cycle, with selected equal to the same value in the cycle before and the cycle of the strobe.
- Rounds and victory: ROUNDS_TO_WIN=2, GAP_CYCLES=10. Respond to each strobe with working and then a done on the selected bit → round_count goes 1 then 2, victory=1. The two selected codes differ.
- Lives: LIVES=3 and three collision pulses during RUN → lives 3→2→1→0, then game_over=1 the next cycle. A done pulse in the same cycle as the third hit is ignored.
- Timeout: never assert working → done_control re-pulses every LAUNCH_TIMEOUT cycles (16). Asserting working at cycle 20 → RUN.
- Abort: menu_on=1 mid-RUN → IDLE next cycle, busy=0, round_count=0 and lives=LIVES reloaded.
- Stray done: obstacle_done of a non-selected bit during RUN → no state change; round_count is unchanged.

Source files
------------

// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle sequencer and the obstacle modules it drives.
// Holds the state encoding, the obstacle select codes and the pixel-clock rate.
package obstacle_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPick   = 3'd1,
    StLaunch = 3'd2,
    StRun    = 3'd3,
    StGap    = 3'd4,
    StWin    = 3'd5,
    StLose   = 3'd6
  } state_e;

  // Each obstacle module compares `selected` against its own code.
  localparam logic [3:0] SelPillar = 4'd0;
  localparam logic [3:0] SelWall   = 4'd1;
  localparam logic [3:0] SelSpikes = 4'd2;
  localparam logic [3:0] SelSaw    = 4'd3;

  localparam int unsigned CyclesPerSec = 65_000_000;

  function automatic logic [3:0] wrap_code(input int unsigned code, input int unsigned n);
    return 4'(code % n);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the obstacle picker.
module lfsr16
  import obstacle_scheduler_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic        feedback;

  assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge pclk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[14:0], feedback};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Game-level sequencer: picks obstacles, launches them, tracks rounds and lives,
// and ends the game with a win or a loss.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned N_OBSTACLES    = 4,
  parameter int unsigned ROUNDS_TO_WIN  = 8,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned GAP_CYCLES     = CyclesPerSec,
  parameter int unsigned LAUNCH_TIMEOUT = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   play_selected,
  input  logic                   menu_on,
  input  logic [N_OBSTACLES-1:0] obstacle_done,
  input  logic [N_OBSTACLES-1:0] obstacle_working,
  input  logic                   collision,
  output logic [3:0]             selected,
  output logic                   done_control,
  output logic [7:0]             round_count,
  output logic [3:0]             lives,
  output logic                   game_over,
  output logic                   victory,
  output logic                   busy
);

  localparam logic [31:0] TimeoutLast =
      32'((LAUNCH_TIMEOUT == 0) ? 0 : LAUNCH_TIMEOUT - 1);
  localparam logic [31:0] GapLoad = 32'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [7:0]  RoundsWin = 8'(ROUNDS_TO_WIN);
  localparam logic [3:0]  LivesInit = 4'(LIVES);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  selected_q, selected_d;
  logic        done_control_q, strobe;
  logic [7:0]  round_count_q, round_count_d, round_next;
  logic [3:0]  lives_q, lives_d;
  logic        game_over_q, victory_q, busy_q;

  logic [15:0] lfsr_value;
  logic        unused_lfsr;
  logic [3:0]  pick_raw, pick;
  logic [15:0] done_ext, working_ext;
  logic        active, hit_state, abort, hit, kill;

  lfsr16 u_lfsr (
    .pclk    (pclk),
    .rst     (rst),
    .seed    (LFSR_SEED),
    .advance (1'b1),
    .value   (lfsr_value)
  );

  assign unused_lfsr = ^lfsr_value[15:4];
  assign done_ext    = 16'(obstacle_done);
  assign working_ext = 16'(obstacle_working);

  // Never repeat the previous obstacle once a game is under way.
  always_comb begin
    pick_raw = wrap_code(32'(lfsr_value[3:0]), N_OBSTACLES);
    pick     = pick_raw;
    if (round_count_q != 8'd0 && pick_raw == selected_q) begin
      pick = wrap_code(32'(pick_raw) + 32'd1, N_OBSTACLES);
    end
  end

  assign round_next = (round_count_q == 8'hFF) ? 8'hFF : round_count_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    selected_d    = selected_q;
    round_count_d = round_count_q;
    lives_d       = lives_q;
    strobe        = 1'b0;

    active    = state_q inside {StPick, StLaunch, StRun, StGap};
    hit_state = state_q inside {StLaunch, StRun, StGap};
    abort     = active && (menu_on || !play_selected);
    hit       = hit_state && collision && (lives_q != 4'd0);
    kill      = hit && (lives_q == 4'd1);

    if (abort) begin
      state_d = StIdle;
    end else if (hit_state && lives_q == 4'd0) begin
      state_d = StLose;
    end else begin
      if (hit) begin
        lives_d = lives_q - 4'd1;
      end
      // The cycle that spends the last life freezes everything else; LOSE follows.
      if (!kill) begin
        unique case (state_q)
          StIdle: begin
            if (play_selected && !menu_on) state_d = StPick;
          end
          StPick: begin
            state_d = StLaunch;
            strobe  = 1'b1;
            timer_d = '0;
          end
          StLaunch: begin
            if (working_ext[selected_q]) begin
              state_d = StRun;
            end else if (timer_q == TimeoutLast) begin
              strobe  = 1'b1;
              timer_d = '0;
            end else begin
              timer_d = timer_q + 32'd1;
            end
          end
          StRun: begin
            if (done_ext[selected_q]) begin
              round_count_d = round_next;
              state_d       = (round_next == RoundsWin) ? StWin : StGap;
              timer_d       = GapLoad;
            end
          end
          StGap: begin
            if (timer_q == 32'd0) begin
              state_d = StPick;
            end else begin
              timer_d = timer_q - 32'd1;
            end
          end
          StWin, StLose: begin
            if (!play_selected) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // Selection is registered on entry to PICK so it is stable a cycle before the strobe.
    if (state_d == StPick && state_q != StPick) begin
      selected_d = pick;
    end

    if (state_d == StIdle) begin
      round_count_d = 8'd0;
      lives_d       = LivesInit;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      selected_q     <= 4'd0;
      done_control_q <= 1'b0;
      round_count_q  <= 8'd0;
      lives_q        <= LivesInit;
      game_over_q    <= 1'b0;
      victory_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      selected_q     <= selected_d;
      done_control_q <= strobe;
      round_count_q  <= round_count_d;
      lives_q        <= lives_d;
      game_over_q    <= (state_d == StLose);
      victory_q      <= (state_d == StWin);
      busy_q         <= state_d inside {StPick, StLaunch, StRun, StGap};
    end
  end

  assign selected     = selected_q;
  assign done_control = done_control_q;
  assign round_count  = round_count_q;
  assign lives        = lives_q;
  assign game_over    = game_over_q;
  assign victory      = victory_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler with a behavioural LFSR/pick model.
module tb_obstacle_scheduler;

  localparam int unsigned N      = 4;
  localparam int unsigned ROUNDS = 2;
  localparam int unsigned NLIVES = 3;
  localparam int unsigned GAP    = 10;
  localparam int unsigned TMO    = 16;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic         pclk = 1'b0;
  logic         rst = 1'b1;
  logic         play_selected, menu_on, collision;
  logic [N-1:0] obstacle_done, obstacle_working;
  logic [3:0]   selected;
  logic         done_control;
  logic [7:0]   round_count;
  logic [3:0]   lives;
  logic         game_over, victory, busy;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  obstacle_scheduler #(
    .N_OBSTACLES    (N),
    .ROUNDS_TO_WIN  (ROUNDS),
    .LIVES          (NLIVES),
    .GAP_CYCLES     (GAP),
    .LAUNCH_TIMEOUT (TMO),
    .LFSR_SEED      (SEED)
  ) dut (
    .pclk             (pclk),
    .rst              (rst),
    .play_selected    (play_selected),
    .menu_on          (menu_on),
    .obstacle_done    (obstacle_done),
    .obstacle_working (obstacle_working),
    .collision        (collision),
    .selected         (selected),
    .done_control     (done_control),
    .round_count      (round_count),
    .lives            (lives),
    .game_over        (game_over),
    .victory          (victory),
    .busy             (busy)
  );

  // Reference LFSR sequence with a two-cycle history, aligned to the DUT's cycles.
  logic [15:0] m_lfsr, m_hist1, m_hist2;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  always @(posedge pclk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);
    m_hist1 <= m_lfsr;
    m_hist2 <= m_hist1;
  end

  function automatic logic [3:0] exp_pick(input logic [15:0] v, input logic [3:0] prev,
                                          input int rounds);
    int p;
    p = int'(v[3:0]) % int'(N);
    if (rounds > 0 && p == int'(prev)) p = (p + 1) % int'(N);
    return 4'(p);
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    play_selected    = 1'b0;
    menu_on          = 1'b0;
    collision        = 1'b0;
    obstacle_done    = '0;
    obstacle_working = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Strobe cycle is two cycles after the pick decision, hence m_hist2.
  task automatic wait_strobe(output bit ok, output logic [3:0] exp, input logic [3:0] prev,
                             input int rounds);
    ok  = 1'b0;
    exp = 4'd0;
    for (int i = 0; i < 300; i++) begin
      if (done_control === 1'b1) begin
        ok  = 1'b1;
        exp = exp_pick(m_hist2, prev, rounds);
        break;
      end
      step();
    end
  endtask

  task automatic ack_working(input logic [3:0] sel, input int delay);
    repeat (delay) step();
    obstacle_working = N'(1 << sel);
    step();
    obstacle_working = '0;
  endtask

  task automatic pulse_done(input logic [3:0] sel);
    obstacle_done = N'(1 << sel);
    step();
    obstacle_done = '0;
  endtask

  task automatic test_reset();
    do_reset();
    play_selected = 1'b1;
    repeat (4) step();
    do_reset();
    checks++; if (selected !== 4'd0) begin errors++; $display("FAIL reset_selected: got %0d want 0", selected); end
    checks++; if (done_control !== 1'b0) begin errors++; $display("FAIL reset_done_control: got %b want 0", done_control); end
    checks++; if (round_count !== 8'd0) begin errors++; $display("FAIL reset_round_count: got %0d want 0", round_count); end
    checks++; if (lives !== 4'(NLIVES)) begin errors++; $display("FAIL reset_lives: got %0d want %0d", lives, NLIVES); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    checks++; if (victory !== 1'b0) begin errors++; $display("FAIL reset_victory: got %b want 0", victory); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_launch();
    logic [3:0] s0, exp;
    do_reset();
    play_selected = 1'b1;
    step();
    exp = exp_pick(m_hist1, 4'd0, 0);
    s0  = selected;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL launch_pick_busy: got %b want 1", busy); end
    checks++; if (done_control !== 1'b0) begin errors++; $display("FAIL launch_pick_strobe: got %b want 0", done_control); end
    checks++; if (selected !== exp) begin errors++; $display("FAIL launch_pick_code: got %0d want %0d", selected, exp); end
    step();
    checks++; if (done_control !== 1'b1) begin errors++; $display("FAIL launch_strobe: got %b want 1", done_control); end
    checks++; if (selected !== s0) begin errors++; $display("FAIL launch_sel_stable: got %0d want %0d", selected, s0); end
    step();
    checks++; if (done_control !== 1'b0) begin errors++; $display("FAIL launch_strobe_len: got %b want 0", done_control); end
    play_selected = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL launch_abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_rounds_victory();
    bit ok;
    logic [3:0] exp, last, sel;
    do_reset();
    play_selected = 1'b1;
    last = 4'd0;
    for (int r = 0; r < int'(ROUNDS); r++) begin
      wait_strobe(ok, exp, last, r);
      checks++; if (!ok) begin errors++; $display("FAIL rounds_strobe_timeout: got none want strobe"); end
      checks++; if (selected !== exp) begin errors++; $display("FAIL rounds_pick: got %0d want %0d", selected, exp); end
      if (r > 0) begin
        checks++; if (selected === last) begin errors++; $display("FAIL rounds_repeat: got %0d want not %0d", selected, last); end
      end
      sel  = selected;
      last = sel;
      ack_working(sel, int'($urandom_range(0, 6)));
      repeat ($urandom_range(0, 4)) step();
      pulse_done(sel);
      checks++; if (round_count !== 8'(r + 1)) begin errors++; $display("FAIL rounds_count: got %0d want %0d", round_count, r + 1); end
      checks++; if (victory !== (r == int'(ROUNDS) - 1)) begin errors++; $display("FAIL rounds_victory: got %b want %b", victory, r == int'(ROUNDS) - 1); end
      checks++; if (busy !== (r != int'(ROUNDS) - 1)) begin errors++; $display("FAIL rounds_busy: got %b want %b", busy, r != int'(ROUNDS) - 1); end
    end
    play_selected = 1'b0;
    step();
    checks++; if (victory !== 1'b0) begin errors++; $display("FAIL win_exit_victory: got %b want 0", victory); end
    checks++; if (round_count !== 8'd0) begin errors++; $display("FAIL win_exit_rounds: got %0d want 0", round_count); end
  endtask

  task automatic test_lives();
    bit ok;
    logic [3:0] exp, sel;
    do_reset();
    play_selected = 1'b1;
    wait_strobe(ok, exp, 4'd0, 0);
    checks++; if (!ok) begin errors++; $display("FAIL lives_strobe_timeout: got none want strobe"); end
    sel = selected;
    ack_working(sel, int'($urandom_range(0, 6)));
    for (int k = 1; k <= 3; k++) begin
      repeat ($urandom_range(0, 3)) step();
      collision = 1'b1;
      if (k == 3) obstacle_done = N'(1 << sel);
      step();
      collision     = 1'b0;
      obstacle_done = '0;
      checks++; if (lives !== 4'(NLIVES - k)) begin errors++; $display("FAIL lives_count: got %0d want %0d", lives, NLIVES - k); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL lives_early_over: got %b want 0", game_over); end
    end
    checks++; if (round_count !== 8'd0) begin errors++; $display("FAIL lives_done_ignored: got %0d want 0", round_count); end
    step();
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL lives_game_over: got %b want 1", game_over); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lives_lose_busy: got %b want 0", busy); end
    collision = 1'b1;
    step();
    collision = 1'b0;
    checks++; if (lives !== 4'd0) begin errors++; $display("FAIL lives_underflow: got %0d want 0", lives); end
    play_selected = 1'b0;
    step();
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL lose_exit: got %b want 0", game_over); end
    checks++; if (lives !== 4'(NLIVES)) begin errors++; $display("FAIL lose_exit_lives: got %0d want %0d", lives, NLIVES); end
  endtask

  task automatic test_timeout();
    bit ok, want;
    logic [3:0] exp, sel;
    do_reset();
    play_selected = 1'b1;
    wait_strobe(ok, exp, 4'd0, 0);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_first_strobe: got none want strobe"); end
    sel = selected;
    for (int i = 1; i <= 34; i++) begin
      step();
      want = (i == int'(TMO));
      checks++; if (done_control !== want) begin errors++; $display("FAIL timeout_strobe_c%0d: got %b want %b", i, done_control, want); end
      if (i == 20) obstacle_working = N'(1 << sel);
    end
    obstacle_working = '0;
    pulse_done(sel);
    checks++; if (round_count !== 8'd1) begin errors++; $display("FAIL timeout_run: got %0d want 1", round_count); end
  endtask

  task automatic test_abort();
    bit ok;
    logic [3:0] exp, sel;
    do_reset();
    play_selected = 1'b1;
    wait_strobe(ok, exp, 4'd0, 0);
    sel = selected;
    ack_working(sel, int'($urandom_range(0, 6)));
    pulse_done(sel);
    wait_strobe(ok, exp, sel, 1);
    checks++; if (!ok) begin errors++; $display("FAIL abort_strobe_timeout: got none want strobe"); end
    checks++; if (selected !== exp) begin errors++; $display("FAIL abort_pick: got %0d want %0d", selected, exp); end
    sel = selected;
    ack_working(sel, int'($urandom_range(0, 6)));
    collision = 1'b1;
    step();
    collision = 1'b0;
    checks++; if (lives !== 4'(NLIVES - 1)) begin errors++; $display("FAIL abort_hit: got %0d want %0d", lives, NLIVES - 1); end
    menu_on = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (round_count !== 8'd0) begin errors++; $display("FAIL abort_rounds: got %0d want 0", round_count); end
    checks++; if (lives !== 4'(NLIVES)) begin errors++; $display("FAIL abort_lives: got %0d want %0d", lives, NLIVES); end
    checks++; if (done_control !== 1'b0) begin errors++; $display("FAIL abort_strobe: got %b want 0", done_control); end
    menu_on = 1'b0;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart: got %b want 1", busy); end
    step();
    play_selected = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_launch_busy: got %b want 0", busy); end
    checks++; if (done_control !== 1'b0) begin errors++; $display("FAIL abort_launch_strobe: got %b want 0", done_control); end
  endtask

  task automatic test_stray_done();
    bit ok;
    logic [3:0] exp, sel;
    logic [N-1:0] mask;
    do_reset();
    play_selected = 1'b1;
    wait_strobe(ok, exp, 4'd0, 0);
    checks++; if (!ok) begin errors++; $display("FAIL stray_strobe_timeout: got none want strobe"); end
    sel = selected;
    ack_working(sel, int'($urandom_range(0, 6)));
    for (int j = 0; j < 8; j++) begin
      mask = N'($urandom) & ~N'(1 << sel);
      if (mask == '0) mask = N'(1 << ((int'(sel) + 1) % int'(N)));
      obstacle_done = mask;
      step();
      obstacle_done = '0;
      checks++; if (round_count !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL stray_done_%0d: got rc=%0d busy=%b want rc=0 busy=1", j, round_count, busy); end
    end
    pulse_done(sel);
    checks++; if (round_count !== 8'd1) begin errors++; $display("FAIL stray_real_done: got %0d want 1", round_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_launch();
    test_rounds_victory();
    test_lives();
    test_timeout();
    test_abort();
    test_stray_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
